// File: rtl/branch_predictor_2bit.sv
// branch_predictor_2bit
//   Two-bit saturating-counter branch predictor for the five-stage MIPS
//   pipeline. It predicts in ID, carries the prediction and its table index
//   through an internal ID->EX register, and resolves in EX. In EX it flags
//   mispredictions and trains the pattern history table (PHT).
//
//   Optional feature: define BP_GSHARE_EN to XOR a global history register
//   into the PHT index (gshare). When it is undefined, the PHT is indexed
//   purely by PC (bimodal) and no history register exists.
//
// Parameters
//   INDEX_W  PHT index width (2^INDEX_W two-bit counters)
//   GHR_W    global history length, gshare only (GHR_W <= INDEX_W)
//
// Ports
//   clk            pipeline clock, rising edge
//   rst            synchronous active-high reset
//   pcD            PC of the instruction in ID
//   branchD        ID instruction is a branch
//   stallE         hold the ID->EX register and suppress training
//   flushE         insert a bubble into EX
//   actual_takenE  resolved branch outcome in EX
//   pred_takenD    prediction for the ID instruction (combinational)
//   pred_takenE    prediction carried with the EX instruction
//   mispredictE    EX branch resolved opposite to its prediction
//   branch_cnt     resolved branches since reset (wraps)
//   miss_cnt       mispredictions since reset (wraps)
module branch_predictor_2bit #(
  parameter int INDEX_W = 6,
  parameter int GHR_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        actual_takenE,
  output logic        pred_takenD,
  output logic        pred_takenE,
  output logic        mispredictE,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Move a two-bit counter one step toward the resolved outcome, pinned at 00/11.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11)
      res = cnt + 2'b01;
    else if (!taken && cnt != 2'b00)
      res = cnt - 2'b01;
    return res;
  endfunction

  logic [1:0]         pht_q [ENTRIES];
  logic [INDEX_W-1:0] idxD;
  logic [INDEX_W-1:0] idxE_q;
  logic               branchE_q;
  logic               pred_takenE_q;
  logic [31:0]        branch_cnt_q;
  logic [31:0]        miss_cnt_q;
  logic               train;

  // Only the word-aligned index bits of the PC feed the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcD[31:INDEX_W+2], pcD[1:0]};

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0]   ghr_q;
  logic [INDEX_W-1:0] ghr_ext;

  assign ghr_ext = INDEX_W'(ghr_q);
  assign idxD    = pcD[INDEX_W+1:2] ^ ghr_ext;

  // History is updated only from resolved EX outcomes (non-speculative).
  always_ff @(posedge clk) begin
    if (rst)
      ghr_q <= '0;
    else if (train)
      ghr_q <= GHR_W'({ghr_q, actual_takenE});
  end
`else
  assign idxD = pcD[INDEX_W+1:2];
`endif

  // ID stage: table read; non-branches never predict taken.
  assign pred_takenD = branchD & pht_q[idxD][1];

  // ID -> EX boundary: flush wins over stall.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      branchE_q     <= 1'b0;
      pred_takenE_q <= 1'b0;
      idxE_q        <= '0;
    end else if (!stallE) begin
      branchE_q     <= branchD;
      pred_takenE_q <= pred_takenD;
      idxE_q        <= idxD;
    end
  end

  // EX stage: resolve and train. Reset priority discards an in-flight branch.
  assign mispredictE = branchE_q & (pred_takenE_q ^ actual_takenE);
  assign train       = branchE_q & ~stallE;

  // Whole table returns to weak-NT in the reset cycle. ID reads the old value
  // on a same-entry write because the read is from the registered array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        pht_q[i] <= 2'b01;
    end else if (train) begin
      pht_q[idxE_q] <= sat_update(pht_q[idxE_q], actual_takenE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (train) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredictE)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign pred_takenE = pred_takenE_q;
  assign branch_cnt  = branch_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Directed testbench for branch_predictor_2bit (default bimodal build).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_branch_predictor_2bit;

  logic        clk;
  logic        rst;
  logic [31:0] pcD;
  logic        branchD;
  logic        stallE;
  logic        flushE;
  logic        actual_takenE;
  logic        pred_takenD;
  logic        pred_takenE;
  logic        mispredictE;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int checks;
  int failures;

  branch_predictor_2bit #(.INDEX_W(6), .GHR_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .pcD           (pcD),
    .branchD       (branchD),
    .stallE        (stallE),
    .flushE        (flushE),
    .actual_takenE (actual_takenE),
    .pred_takenD   (pred_takenD),
    .pred_takenE   (pred_takenE),
    .mispredictE   (mispredictE),
    .branch_cnt    (branch_cnt),
    .miss_cnt      (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one branch, then resolve it in the next cycle. Returns the ID
  // prediction and the EX mispredict flag; training happens on the next edge.
  task automatic branch_op(input logic [31:0] pc, input logic actual,
                           output logic predD, output logic misE);
    @(negedge clk);
    branchD = 1'b1; pcD = pc; stallE = 1'b0; flushE = 1'b0; actual_takenE = 1'b0;
    #1 predD = pred_takenD;
    @(negedge clk);
    branchD = 1'b0; actual_takenE = actual;
    #1 misE = mispredictE;
  endtask

  task automatic test_reset();
    rst = 1'b1; branchD = 1'b0; pcD = '0; stallE = 1'b0; flushE = 1'b0; actual_takenE = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    branchD = 1'b1; pcD = 32'h0040_0010;
    #1;
    checks++;
    if (pred_takenE !== 1'b0) begin failures++; $display("FAIL reset_predE got=%0b exp=0", pred_takenE); end
    checks++;
    if (mispredictE !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%0b exp=0", mispredictE); end
    checks++;
    if (branch_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_cnt, miss_cnt);
    end
    checks++;
    if (pred_takenD !== 1'b0) begin failures++; $display("FAIL reset_predD got=%0b exp=0", pred_takenD); end
    branchD = 1'b0;
  endtask

  task automatic test_first_branch();
    logic p, m;
    branch_op(32'h0040_0010, 1'b1, p, m);
    checks++;
    if (p !== 1'b0) begin failures++; $display("FAIL first_pred got=%0b exp=0", p); end
    checks++;
    if (m !== 1'b1) begin failures++; $display("FAIL first_mispredict got=%0b exp=1", m); end
    @(negedge clk);
    actual_takenE = 1'b0;
    #1;
    checks++;
    if (branch_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      failures++; $display("FAIL first_counts got=%0d/%0d exp=1/1", branch_cnt, miss_cnt);
    end
  endtask

  task automatic test_saturate();
    logic p, m;
    branch_op(32'h0040_0010, 1'b1, p, m);
    checks++;
    if (p !== 1'b1 || m !== 1'b0) begin failures++; $display("FAIL sat_second got=%0b%0b exp=10", p, m); end
    branch_op(32'h0040_0010, 1'b1, p, m);
    checks++;
    if (p !== 1'b1 || m !== 1'b0) begin failures++; $display("FAIL sat_third got=%0b%0b exp=10", p, m); end
    @(negedge clk);
    actual_takenE = 1'b0;
    #1;
    checks++;
    if (branch_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
      failures++; $display("FAIL sat_counts got=%0d/%0d exp=3/1", branch_cnt, miss_cnt);
    end
  endtask

  task automatic test_not_taken();
    logic p, m;
    branch_op(32'h0040_0010, 1'b0, p, m);
    checks++;
    if (p !== 1'b1 || m !== 1'b1) begin failures++; $display("FAIL nt_first got=%0b%0b exp=11", p, m); end
    branch_op(32'h0040_0010, 1'b0, p, m);
    checks++;
    if (p !== 1'b1 || m !== 1'b1) begin failures++; $display("FAIL nt_second got=%0b%0b exp=11", p, m); end
    @(negedge clk);
    actual_takenE = 1'b0; branchD = 1'b1; pcD = 32'h0040_0010;
    #1;
    checks++;
    if (pred_takenD !== 1'b0) begin failures++; $display("FAIL nt_after_two got=%0b exp=0", pred_takenD); end
    checks++;
    if (branch_cnt !== 32'd5 || miss_cnt !== 32'd3) begin
      failures++; $display("FAIL nt_counts got=%0d/%0d exp=5/3", branch_cnt, miss_cnt);
    end
    branchD = 1'b0;
  endtask

  task automatic test_non_branch();
    logic p, m;
    branch_op(32'h0040_0020, 1'b1, p, m);
    branch_op(32'h0040_0020, 1'b1, p, m);
    checks++;
    if (p !== 1'b1 || m !== 1'b0) begin failures++; $display("FAIL nb_train got=%0b%0b exp=10", p, m); end
    @(negedge clk);
    branchD = 1'b0; pcD = 32'h0040_0020; actual_takenE = 1'b1;
    #1;
    checks++;
    if (pred_takenD !== 1'b0) begin failures++; $display("FAIL nb_predD got=%0b exp=0", pred_takenD); end
    @(negedge clk);
    #1;
    checks++;
    if (pred_takenE !== 1'b0 || mispredictE !== 1'b0) begin
      failures++; $display("FAIL nb_ex got=%0b%0b exp=00", pred_takenE, mispredictE);
    end
    @(negedge clk);
    actual_takenE = 1'b0;
    #1;
    checks++;
    if (branch_cnt !== 32'd7 || miss_cnt !== 32'd4) begin
      failures++; $display("FAIL nb_counts got=%0d/%0d exp=7/4", branch_cnt, miss_cnt);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    branchD = 1'b1; pcD = 32'h0040_0030;
    @(negedge clk);
    branchD = 1'b0; stallE = 1'b1; actual_takenE = 1'b1;
    #1;
    checks++;
    if (mispredictE !== 1'b1) begin failures++; $display("FAIL stall_mispredict got=%0b exp=1", mispredictE); end
    repeat (3) @(negedge clk);
    stallE = 1'b0;
    #1;
    checks++;
    if (branch_cnt !== 32'd7 || miss_cnt !== 32'd4) begin
      failures++; $display("FAIL stall_held_counts got=%0d/%0d exp=7/4", branch_cnt, miss_cnt);
    end
    @(negedge clk);
    actual_takenE = 1'b0; branchD = 1'b1; pcD = 32'h0040_0030;
    #1;
    checks++;
    if (branch_cnt !== 32'd8 || miss_cnt !== 32'd5) begin
      failures++; $display("FAIL stall_release_counts got=%0d/%0d exp=8/5", branch_cnt, miss_cnt);
    end
    checks++;
    if (pred_takenD !== 1'b1) begin failures++; $display("FAIL stall_trained_pred got=%0b exp=1", pred_takenD); end
    branchD = 1'b0;
  endtask

  task automatic test_flush_stall();
    @(negedge clk);
    branchD = 1'b1; pcD = 32'h0040_0030;
    @(negedge clk);
    branchD = 1'b0;
    #1;
    checks++;
    if (pred_takenE !== 1'b1) begin failures++; $display("FAIL flush_pre_predE got=%0b exp=1", pred_takenE); end
    stallE = 1'b1; flushE = 1'b1; actual_takenE = 1'b0;
    @(negedge clk);
    stallE = 1'b0; flushE = 1'b0;
    #1;
    checks++;
    if (pred_takenE !== 1'b0 || mispredictE !== 1'b0) begin
      failures++; $display("FAIL flush_predE got=%0b%0b exp=00", pred_takenE, mispredictE);
    end
    checks++;
    if (branch_cnt !== 32'd8 || miss_cnt !== 32'd5) begin
      failures++; $display("FAIL flush_counts got=%0d/%0d exp=8/5", branch_cnt, miss_cnt);
    end
    branchD = 1'b1; pcD = 32'h0040_0030;
    #1;
    checks++;
    if (pred_takenD !== 1'b1) begin failures++; $display("FAIL flush_untrained got=%0b exp=1", pred_takenD); end
    branchD = 1'b0;
  endtask

  task automatic test_alias();
    logic p, m;
    branch_op(32'h0000_0000, 1'b1, p, m);
    checks++;
    if (p !== 1'b0 || m !== 1'b1) begin failures++; $display("FAIL alias_train got=%0b%0b exp=01", p, m); end
    @(negedge clk);
    actual_takenE = 1'b0; branchD = 1'b1; pcD = 32'h0000_0100;
    #1;
    checks++;
    if (pred_takenD !== 1'b1) begin failures++; $display("FAIL alias_pred got=%0b exp=1", pred_takenD); end
    branchD = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    branchD = 1'b1; pcD = 32'h0040_0050; actual_takenE = 1'b0;
    @(negedge clk);
    actual_takenE = 1'b1;
    #1;
    checks++;
    if (pred_takenD !== 1'b0 || mispredictE !== 1'b1) begin
      failures++; $display("FAIL b2b_old_value got=%0b%0b exp=01", pred_takenD, mispredictE);
    end
    @(negedge clk);
    branchD = 1'b0;
    #1;
    checks++;
    if (pred_takenE !== 1'b0 || mispredictE !== 1'b1) begin
      failures++; $display("FAIL b2b_second_ex got=%0b%0b exp=01", pred_takenE, mispredictE);
    end
    @(negedge clk);
    actual_takenE = 1'b0; branchD = 1'b1; pcD = 32'h0040_0050;
    #1;
    checks++;
    if (branch_cnt !== 32'd11 || miss_cnt !== 32'd8) begin
      failures++; $display("FAIL b2b_counts got=%0d/%0d exp=11/8", branch_cnt, miss_cnt);
    end
    checks++;
    if (pred_takenD !== 1'b1) begin failures++; $display("FAIL b2b_pred got=%0b exp=1", pred_takenD); end
    branchD = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic p, m;
    @(negedge clk);
    branchD = 1'b1; pcD = 32'h0040_0060;
    @(negedge clk);
    branchD = 1'b0; rst = 1'b1; actual_takenE = 1'b1;
    @(negedge clk);
    rst = 1'b0; actual_takenE = 1'b0;
    #1;
    checks++;
    if (branch_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      failures++; $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", branch_cnt, miss_cnt);
    end
    checks++;
    if (pred_takenE !== 1'b0 || mispredictE !== 1'b0) begin
      failures++; $display("FAIL rstmid_ex got=%0b%0b exp=00", pred_takenE, mispredictE);
    end
    branchD = 1'b1; pcD = 32'h0040_0020;
    #1;
    checks++;
    if (pred_takenD !== 1'b0) begin failures++; $display("FAIL rstmid_pht got=%0b exp=0", pred_takenD); end
    branchD = 1'b0;
    branch_op(32'h0040_0060, 1'b1, p, m);
    checks++;
    if (p !== 1'b0 || m !== 1'b1) begin failures++; $display("FAIL rstmid_fresh got=%0b%0b exp=01", p, m); end
    @(negedge clk);
    actual_takenE = 1'b0;
    #1;
    checks++;
    if (branch_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      failures++; $display("FAIL rstmid_recount got=%0d/%0d exp=1/1", branch_cnt, miss_cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_first_branch();
    test_saturate();
    test_not_taken();
    test_non_branch();
    test_stall();
    test_flush_stall();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_2bit.md
# branch_predictor_2bit

Two-bit saturating-counter branch predictor that sits directly downstream of the decode-stage controller in the five-stage MIPS pipeline. It consumes `branchD` and the decode-stage PC, and produces a taken/not-taken prediction in ID. It carries that prediction and its table index through an internal ID→EX register. In EX it compares the prediction against the resolved outcome, raises a mispredict flag for hazard/PC-select logic, and trains the pattern history table.

## Interface
Parameters:
- `INDEX_W`, 6: PHT index width; table holds 2^INDEX_W two-bit counters.
- `GHR_W`, 6: global history length, used only with gshare (must be ≤ INDEX_W).

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `pcD`  in  32  PC of instruction in ID
- `branchD`  in  1  controller's branch decode for the ID instruction
- `stallE`  in  1  hold ID→EX register and suppress training
- `flushE`  in  1  bubble into EX (clears carried prediction)
- `actual_takenE`  in  1  resolved branch condition in EX
- `pred_takenD`  out  1  prediction for ID instruction (combinational)
- `pred_takenE`  out  1  carried prediction of EX instruction
- `mispredictE`  out  1  EX branch resolved opposite to prediction
- `branch_cnt`  out  32  resolved branches since reset
- `miss_cnt`  out  32  mispredictions since reset

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when bit[1]=1.
- Index in ID: `pcD[INDEX_W+1:2]` (word-aligned), or the gshare variant under Configuration.
- `pred_takenD = branchD & pht[idxD][1]`. It is 0 for non-branches regardless of table contents.
- ID→EX register holds `branchE`, `pred_takenE`, `idxE`.
  - On `rst` or `flushE`: all cleared to 0. Flush wins over stall.
  - Else if `!stallE`: loaded from the ID values.
  - Else: held.
- `mispredictE = branchE & (pred_takenE ^ actual_takenE)`. This is combinational, and it is 0 when `branchE`=0.
- Training happens on the rising edge when `branchE & !stallE & !rst`:
  - `actual_takenE`=1 increments `pht[idxE]`, saturating at 11.
  - `actual_takenE`=0 decrements `pht[idxE]`, saturating at 00.
  - All other entries are unchanged.
- Statistics: on the same training condition, `branch_cnt` increments. `miss_cnt` also increments if `mispredictE` is 1. Both counters wrap at 2^32 with no saturation.
- Same-cycle read and write of one entry: the ID read returns the pre-update (old) value. There is no bypass.

## Timing
- Reset values:
  - every PHT entry = 01 (weak-NT)
  - `pred_takenE`=0, `mispredictE`=0, `branch_cnt`=0, `miss_cnt`=0
  - GHR=0
  - `pred_takenD` follows its equation (0 after reset, since entries are weak-NT)
- PHT reset takes a single cycle: all entries clear in the `rst` cycle. There is no sequenced init FSM.
- Latency:
  - prediction is 0 cycles (same cycle as `branchD`)
  - an EX outcome affects predictions from the next cycle onward
- Reset asserted mid-operation: the in-flight EX branch is discarded untrained, and counts are not incremented.

## Configuration
- `BP_GSHARE_EN` defined:
  - Index = `pcD[INDEX_W+1:2] ^ {{(INDEX_W-GHR_W){1'b0}}, ghr}`.
  - `ghr` (GHR_W bits) shifts left with `actual_takenE` inserted at bit 0, under the same training condition.
  - GHR updates are non-speculative (EX only).
  - `idxE` carries the ID-time hashed index, so training uses the index the prediction was made with.
- `BP_GSHARE_EN` undefined: pure bimodal PC indexing; the GHR is not instantiated.

## Test plan
- Reset, then `branchD`=1, `pcD`=0x0040_0010 → `pred_takenD`=0. Resolve taken → `mispredictE`=1, `miss_cnt`=1, `branch_cnt`=1.
- Same PC taken three times → predictions 0,1,1; counter 01→10→11→11 (saturates); `miss_cnt`=1.
- From strong-T, resolve not-taken once → next prediction still 1 (counter 10). Twice → 0.
- `branchD`=0 with a trained-taken entry → `pred_takenD`=0; no training; counts unchanged.
- Stall and flush:
  - `stallE`=1 for 3 cycles with `branchE`=1 → exactly one training and `branch_cnt`+1 after release.
  - `flushE`=1 together with `stallE`=1 → `pred_takenE`=0 and no training.
- `BP_GSHARE_EN`, aliasing: two PCs 0x100 and 0x200 with alternating outcomes, GHR=0b000001 after one taken → indices differ by 1 and train independently. Without the macro, PCs 0x0 and 0x100 alias to one entry (INDEX_W=6).
